// File: rtl/output_deskew_buffer_if.sv
// rtl/output_deskew_buffer_if.sv - stream-side signal bundle for output_deskew_buffer
//
// Purpose: groups the skewed input stream and the aligned FIFO output stream.
// Signals:
//   in_valid  column-0 result valid (column j follows j cycles later)
//   in_res    skewed results, lane j in bits [(j+1)*DW-1 : j*DW]
//   out_valid aligned row available at the FIFO head
//   out_ready consumer accepts the head row
//   out_res   aligned head row, same lane mapping as in_res
// Modports: master = producer/consumer side, slave = the deskew buffer.
interface output_deskew_buffer_if #(
    parameter int AW = 4,
    parameter int DW = 32
);
    logic              in_valid;
    logic [AW*DW-1:0]  in_res;
    logic              out_valid;
    logic              out_ready;
    logic [AW*DW-1:0]  out_res;

    modport master (
        output in_valid,
        output in_res,
        output out_ready,
        input  out_valid,
        input  out_res
    );

    modport slave (
        input  in_valid,
        input  in_res,
        input  out_ready,
        output out_valid,
        output out_res
    );
endinterface

// File: rtl/output_deskew_buffer.sv
// rtl/output_deskew_buffer.sv - realigns skewed systolic-array results into a row FIFO
//
// Purpose: lane j of the array output arrives j cycles after lane 0. Each lane
// is delayed by AW-1-j register stages so a whole row lines up, then the row
// is pushed into a first-word-fall-through FIFO of DEPTH entries.
// Optional feature: define OUTBUF_RELU_EN to clamp negative lanes to 0 at FIFO write.
// Ports:
//   clk       rising-edge clock
//   rst       synchronous active-low reset
//   io        output_deskew_buffer_if.slave (in_valid/in_res, out_valid/out_ready/out_res)
//   full      FIFO holds DEPTH rows
//   empty     FIFO holds no rows
//   count     FIFO occupancy
//   overflow  sticky: an aligned row was dropped because the FIFO was full
module output_deskew_buffer #(
    parameter int AW    = 4,
    parameter int DW    = 32,
    parameter int DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    output_deskew_buffer_if.slave        io,
    output logic                         full,
    output logic                         empty,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic                         overflow
);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int PW = $clog2(DEPTH);

    logic [AW*DW-1:0] aligned;
    logic [AW*DW-1:0] wr_row;
    logic             wr_v;

    // Per-lane delay lines: lane j needs AW-1-j stages so every lane of a row
    // reaches the FIFO on the same edge as lane AW-1, which is undelayed.
    for (genvar j = 0; j < AW; j++) begin : g_lane
        localparam int NS = AW - 1 - j;
        if (NS == 0) begin : g_direct
            assign aligned[j*DW +: DW] = io.in_res[j*DW +: DW];
        end else begin : g_delay
            logic [DW-1:0] stg [NS];
            always_ff @(posedge clk) begin
                if (!rst) begin
                    for (int k = 0; k < NS; k++) stg[k] <= '0;
                end else begin
                    stg[0] <= io.in_res[j*DW +: DW];
                    for (int k = 1; k < NS; k++) stg[k] <= stg[k-1];
                end
            end
            assign aligned[j*DW +: DW] = stg[NS-1];
        end
    end

    // Valid follows lane 0's path so wr_v marks the edge the row is complete.
    if (AW == 1) begin : g_vld_direct
        assign wr_v = io.in_valid;
    end else begin : g_vld_delay
        logic [AW-2:0] vld;
        always_ff @(posedge clk) begin
            if (!rst) begin
                vld <= '0;
            end else begin
                vld[0] <= io.in_valid;
                for (int k = 1; k < AW - 1; k++) vld[k] <= vld[k-1];
            end
        end
        assign wr_v = vld[AW-2];
    end

    always_comb begin
        wr_row = aligned;
`ifdef OUTBUF_RELU_EN
        for (int j = 0; j < AW; j++) begin
            if (aligned[j*DW + DW - 1]) wr_row[j*DW +: DW] = '0;
        end
`endif
    end

    logic [AW*DW-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic             push;
    logic             pop;

    assign full         = (count == CW'(DEPTH));
    assign empty        = (count == '0);
    assign io.out_valid = !empty;
    assign io.out_res   = empty ? '0 : mem[rd_ptr];
    assign pop          = io.out_valid && io.out_ready;
    // A simultaneous pop frees the slot, so a push at full is still accepted.
    assign push         = wr_v && (!full || pop);

    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PW'(1);
            if (pop)  rd_ptr <= rd_ptr + PW'(1);
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
            if (wr_v && !push) overflow <= 1'b1;
        end
    end

    // Storage is not reset: pointers and count define which entries are live.
    always_ff @(posedge clk) begin
        if (rst && push) mem[wr_ptr] <= wr_row;
    end
endmodule

// File: tb/tb_output_deskew_buffer.sv
// tb/tb_output_deskew_buffer.sv - scoreboard bench for output_deskew_buffer
module tb_output_deskew_buffer;
    localparam int AW    = 4;
    localparam int DW    = 32;
    localparam int DEPTH = 4;
    localparam int RW    = AW * DW;
    localparam int NE    = 720;

    logic clk = 1'b0;
    logic rst;
    logic full, empty, overflow;
    logic [$clog2(DEPTH+1)-1:0] count;

    output_deskew_buffer_if #(.AW(AW), .DW(DW)) bus ();

    output_deskew_buffer #(.AW(AW), .DW(DW), .DEPTH(DEPTH)) dut (
        .clk      (clk),
        .rst      (rst),
        .io       (bus.slave),
        .full     (full),
        .empty    (empty),
        .count    (count),
        .overflow (overflow)
    );

    always #5 clk = ~clk;

    bit          sched_v    [NE];
    bit          sched_rdy  [NE];
    bit          sched_rstn [NE];
    logic [RW-1:0] sched_row [NE];

    logic [RW-1:0] exp_q [$];
    int  mocc     = 0;
    int  movf     = 0;
    int  last_rst = -1;
    bit  mon_en   = 0;
    int  total    = 0;
    int  bad      = 0;

    task automatic chk(input string nm, input logic [RW-1:0] act, input logic [RW-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    function automatic logic [RW-1:0] relu(input logic [RW-1:0] r);
        logic [RW-1:0] o;
        o = r;
`ifdef OUTBUF_RELU_EN
        for (int j = 0; j < AW; j++)
            if ($signed(r[j*DW +: DW]) < 0) o[j*DW +: DW] = '0;
`endif
        return o;
    endfunction

    function automatic logic [RW-1:0] rand_row();
        logic [RW-1:0] r;
        for (int j = 0; j < AW; j++) r[j*DW +: DW] = $urandom;
        return r;
    endfunction

    // Reference: a row whose column 0 is sampled at edge a reaches the FIFO at
    // edge a+AW-1, unless a reset edge occurred at or after a.
    task automatic model_update(input int e);
        bit pop_m, arr;
        int a;
        if (!sched_rstn[e]) begin
            exp_q.delete();
            mocc     = 0;
            movf     = 0;
            last_rst = e;
        end else begin
            pop_m = (mocc > 0) && sched_rdy[e];
            a     = e - (AW - 1);
            arr   = (a >= 0) && (a > last_rst) && sched_v[a];
            if (arr) begin
                if (mocc < DEPTH || pop_m) begin
                    exp_q.push_back(relu(sched_row[a]));
                    mocc++;
                end else begin
                    movf = 1;
                end
            end
            if (pop_m) mocc--;
        end
    endtask

    // Monitor: compares DUT state with the model between edges; on a handshake
    // the scoreboard head is retired.
    always @(negedge clk) begin
        if (mon_en) begin
            chk("out_valid", RW'(bus.out_valid), RW'(mocc > 0));
            chk("count",     RW'(count),         RW'(mocc));
            chk("full",      RW'(full),          RW'(mocc == DEPTH));
            chk("empty",     RW'(empty),         RW'(mocc == 0));
            chk("overflow",  RW'(overflow),      RW'(movf));
            if (mocc > 0 && exp_q.size() > 0) begin
                chk("out_res", bus.out_res, exp_q[0]);
                if (bus.out_ready) void'(exp_q.pop_front());
            end else begin
                chk("out_res_idle", bus.out_res, '0);
            end
        end
    end

    initial begin
        logic [RW-1:0] v;

        for (int e = 0; e < NE; e++) begin
            sched_v[e]    = 0;
            sched_rdy[e]  = 1;
            sched_rstn[e] = 1;
            sched_row[e]  = rand_row();
        end
        for (int e = 0; e < 3; e++) sched_rstn[e] = 0;
        // skew: lane j = 0x10+j
        sched_v[5]   = 1;
        sched_row[5] = {32'h13, 32'h12, 32'h11, 32'h10};
        // stream of 6 back-to-back rows
        for (int e = 12; e < 18; e++) sched_v[e] = 1;
        // overflow: 5 rows with no consumer, then drain
        for (int e = 24; e < 40; e++) sched_rdy[e] = 0;
        for (int e = 25; e < 30; e++) sched_v[e] = 1;
        // fill to full, then push with a simultaneous pop
        for (int e = 50; e < 61; e++) sched_rdy[e] = 0;
        for (int e = 50; e < 54; e++) sched_v[e] = 1;
        sched_v[58] = 1;
        for (int e = 62; e < 65; e++) sched_rdy[e] = 0;
        // reset with 2 stored rows and 1 in flight
        for (int e = 80; e < 96; e++) sched_rdy[e] = 0;
        sched_v[80]    = 1;
        sched_v[81]    = 1;
        sched_v[86]    = 1;
        sched_rstn[87] = 0;
        // sign handling
        sched_v[102]   = 1;
        sched_row[102] = {32'h7, 32'h8000_0000, 32'h5, 32'hFFFF_FFF0};
        // random traffic
        for (int e = 110; e < 700; e++) begin
            sched_v[e]    = ($urandom % 2) == 0;
            sched_rdy[e]  = ($urandom % 5) < 3;
            sched_rstn[e] = ($urandom % 200) != 0;
        end

        for (int e = 0; e < NE; e++) begin
            rst           = sched_rstn[e];
            bus.in_valid  = sched_v[e];
            bus.out_ready = sched_rdy[e];
            for (int j = 0; j < AW; j++) begin
                if (e - j >= 0 && sched_v[e-j]) v[j*DW +: DW] = sched_row[e-j][j*DW +: DW];
                else                            v[j*DW +: DW] = $urandom;
            end
            bus.in_res = v;
            @(posedge clk);
            #1;
            model_update(e);
            mon_en = 1;
        end
        @(negedge clk);
        #1;
        chk("drained", RW'(exp_q.size()), '0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
